// File: rtl/frame_sequencer_if.sv
// Signal bundle between the frame sequencer and the MCU link, filter, peak finder and DAC.
// The sequencer takes the master side; the surrounding datapath takes the slave side.
interface frame_sequencer_if #(
    parameter int SAMPLE_W = 10
);
    logic                sck;
    logic                sdo;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                filt_start;
    logic                filt_done;
    logic [SAMPLE_W-1:0] filt_data;
    logic                peak_en;
    logic                dac_data;
    logic                dac_clk;
    logic                dac_load;
    logic                ldac;
    logic                busy;
    logic                overrun;
    logic                filt_err;
    logic                frame_err;
    logic [15:0]         frame_count;

    modport master (
        input  sck, sdo, filt_done, filt_data,
        output sample, sample_valid, filt_start, peak_en,
        output dac_data, dac_clk, dac_load, ldac,
        output busy, overrun, filt_err, frame_err, frame_count
    );

    modport slave (
        output sck, sdo, filt_done, filt_data,
        input  sample, sample_valid, filt_start, peak_en,
        input  dac_data, dac_clk, dac_load, ldac,
        input  busy, overrun, filt_err, frame_err, frame_count
    );
endinterface

// File: rtl/frame_sequencer.sv
// Central per-sample scheduler: SPI frame capture, filter handshake and DAC serializer.
// One state machine replaces the per-module sck bit counters.
module frame_sequencer #(
    parameter int         FRAME_BITS   = 16,
    parameter int         SAMPLE_W     = 10,
    parameter int         DAC_DIV      = 4,
    parameter int         IDLE_TIMEOUT = 4096,
    parameter int         FILT_TIMEOUT = 64,
    parameter logic [1:0] DAC_ADDR     = 2'b00,
    parameter logic       DAC_RNG      = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    frame_sequencer_if.master bus
);
    localparam int BCW = $clog2(FRAME_BITS + 1);
    localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
    localparam int FCW = $clog2(FILT_TIMEOUT + 1);
    localparam int DCW = $clog2(2 * DAC_DIV + 1);

    localparam logic [BCW-1:0] BC_LAST = BCW'(FRAME_BITS - 1);
    localparam logic [ICW-1:0] IC_LAST = ICW'(IDLE_TIMEOUT - 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(FILT_TIMEOUT - 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(2 * DAC_DIV - 1);
    localparam logic [DCW-1:0] DC_HALF = DCW'(DAC_DIV);
    localparam logic [3:0]     DB_LAST = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        FILTER,
        DAC_SHIFT,
        DAC_LOAD
    } state_e;

    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic sdo_s1_q, sdo_s2_q;
    logic sck_rise;

    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ICW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  svalid_q, svalid_d;
    logic [15:0]           fcount_q, fcount_d;
    logic                  frame_err_q, frame_err_d;

    state_e         state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [3:0]     dbit_q, dbit_d;
    logic [10:0]    dw_q, dw_d;
    logic           dac_data_q, dac_data_d;
    logic           peak_q, peak_d;
    logic           overrun_q, overrun_d;
    logic           filt_err_q, filt_err_d;

    logic [10:0] dac_word;
    logic        filt_start;
    logic        dac_clk;
    logic        dac_load;
    logic        busy;
    logic        unused_bits;

    assign sck_rise    = sck_s2_q & ~sck_s3_q;
    assign dac_word    = {DAC_ADDR, DAC_RNG, bus.filt_data[SAMPLE_W-1:SAMPLE_W-8]};
    assign unused_bits = ^{bus.filt_data[SAMPLE_W-9:0], shreg_q[FRAME_BITS-1]};

    // Frame assembly and partial-frame watchdog
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        sample_d    = sample_q;
        svalid_d    = 1'b0;
        fcount_d    = fcount_q;
        frame_err_d = frame_err_q;
        if (sck_rise) begin
            shreg_d    = {shreg_q[FRAME_BITS-2:0], sdo_s2_q};
            idle_cnt_d = '0;
            if (bit_cnt_q == BC_LAST) begin
                bit_cnt_d = '0;
                sample_d  = shreg_d[SAMPLE_W-1:0];
                svalid_d  = 1'b1;
                fcount_d  = fcount_q + 16'd1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q != '0) begin
            if (idle_cnt_q == IC_LAST) begin
                bit_cnt_d   = '0;
                idle_cnt_d  = '0;
                frame_err_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_s3_q    <= 1'b0;
            sdo_s1_q    <= 1'b0;
            sdo_s2_q    <= 1'b0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            sample_q    <= '0;
            svalid_q    <= 1'b0;
            fcount_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sck_s1_q    <= bus.sck;
            sck_s2_q    <= sck_s1_q;
            sck_s3_q    <= sck_s2_q;
            sdo_s1_q    <= bus.sdo;
            sdo_s2_q    <= sdo_s1_q;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            sample_q    <= sample_d;
            svalid_q    <= svalid_d;
            fcount_q    <= fcount_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            dcnt_q     <= '0;
            dbit_q     <= '0;
            dw_q       <= '0;
            dac_data_q <= 1'b0;
            peak_q     <= 1'b0;
            overrun_q  <= 1'b0;
            filt_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            dcnt_q     <= dcnt_d;
            dbit_q     <= dbit_d;
            dw_q       <= dw_d;
            dac_data_q <= dac_data_d;
            peak_q     <= peak_d;
            overrun_q  <= overrun_d;
            filt_err_q <= filt_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        dcnt_d     = dcnt_q;
        dbit_d     = dbit_q;
        dw_d       = dw_q;
        dac_data_d = dac_data_q;
        peak_d     = 1'b0;
        overrun_d  = overrun_q;
        filt_err_d = filt_err_q;
        if (svalid_q && state_q != IDLE) begin
            overrun_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (svalid_q) begin
                    state_d = FILTER;
                    fcnt_d  = '0;
                end
            end
            FILTER: begin
                if (bus.filt_done) begin
                    state_d    = DAC_SHIFT;
                    dac_data_d = dac_word[10];
                    dw_d       = {dac_word[9:0], 1'b0};
                    peak_d     = 1'b1;
                    dcnt_d     = '0;
                    dbit_d     = '0;
                end else if (fcnt_q == FC_LAST) begin
                    state_d    = IDLE;
                    filt_err_d = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            DAC_SHIFT: begin
                if (dcnt_q == DC_LAST) begin
                    dcnt_d = '0;
                    if (dbit_q == DB_LAST) begin
                        state_d = DAC_LOAD;
                    end else begin
                        dbit_d     = dbit_q + 1'b1;
                        dac_data_d = dw_q[10];
                        dw_d       = {dw_q[9:0], 1'b0};
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            DAC_LOAD: begin
                if (dcnt_q == DC_LAST) begin
                    dcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Each DAC bit: low half then high half of dac_clk
    always_comb begin
        filt_start = (state_q == IDLE) && svalid_q;
        dac_clk    = (state_q == DAC_SHIFT) && (dcnt_q >= DC_HALF);
        dac_load   = (state_q != DAC_LOAD);
        busy       = (state_q != IDLE);
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = svalid_q;
    assign bus.filt_start   = filt_start;
    assign bus.peak_en      = peak_q;
    assign bus.dac_data     = dac_data_q;
    assign bus.dac_clk      = dac_clk;
    assign bus.dac_load     = dac_load;
    assign bus.ldac         = 1'b0;
    assign bus.busy         = busy;
    assign bus.overrun      = overrun_q;
    assign bus.filt_err     = filt_err_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.frame_count  = fcount_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: vector table, random transactions against a word-level
// model, and hand sequences for overrun, filter timeout, broken frame and reset.
module tb_frame_sequencer;
    localparam int DAC_DIV = 4;
    localparam int FILT_TO = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_sequencer_if #(.SAMPLE_W(10)) bus ();

    frame_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] w;
        logic [9:0]  fd;
        int          lat;
        logic [9:0]  es;
        logic [10:0] ed;
    } vec_t;

    vec_t tbl [4];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_sv = 0, n_fs = 0, n_pk = 0, n_dbit = 0, n_ld = 0;
    int fs_cyc = 0, pk_cyc = 0;
    logic dclk_prev = 1'b0;
    logic [10:0] dac_cap = '0;
    logic [15:0] exp_fc = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.sample_valid) n_sv++;
        if (bus.filt_start) begin
            n_fs++;
            fs_cyc = cyc;
        end
        if (bus.peak_en) begin
            n_pk++;
            pk_cyc = cyc;
        end
        if (bus.dac_clk && !dclk_prev) begin
            dac_cap = {dac_cap[9:0], bus.dac_data};
            n_dbit++;
        end
        dclk_prev = bus.dac_clk;
        if (!bus.dac_load) n_ld++;
    endtask

    task automatic send_frame(input logic [15:0] w, input int nbits, input int half);
        for (int i = 15; i >= 16 - nbits; i--) begin
            bus.sdo = w[i];
            bus.sck = 1'b0;
            repeat (half) tick();
            bus.sck = 1'b1;
            repeat (half) tick();
        end
        bus.sck = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int t_end);
        int t;
        t = 0;
        while (bus.busy && t < 400) begin
            tick();
            t++;
        end
        if (t >= 400) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: busy still %0d after %0d cycles", nm, bus.busy, t);
        end
        t_end = cyc;
    endtask

    task automatic run_txn(input string nm, input logic [15:0] w, input logic [9:0] fd,
                           input int lat, input logic [9:0] es, input logic [10:0] ed);
        int sv0, fs0, pk0, db0, ld0, dc, te;
        sv0 = n_sv; fs0 = n_fs; pk0 = n_pk; db0 = n_dbit; ld0 = n_ld;
        send_frame(w, 16, 8);
        exp_fc = exp_fc + 16'd1;
        check({nm, " sample"}, 32'(bus.sample), 32'(es));
        check({nm, " sv_cnt"}, n_sv - sv0, 1);
        check({nm, " fs_cnt"}, n_fs - fs0, 1);
        check({nm, " fcount"}, 32'(bus.frame_count), 32'(exp_fc));
        while (cyc < fs_cyc + lat) tick();
        bus.filt_done = 1'b1;
        bus.filt_data = fd;
        dc = cyc;
        tick();
        bus.filt_done = 1'b0;
        bus.filt_data = ~fd;
        wait_idle(nm, te);
        check({nm, " pk_cnt"}, n_pk - pk0, 1);
        check({nm, " pk_lat"}, pk_cyc - dc, 1);
        check({nm, " dac_word"}, 32'(dac_cap), 32'(ed));
        check({nm, " dac_bits"}, n_dbit - db0, 11);
        check({nm, " load_len"}, n_ld - ld0, 2 * DAC_DIV);
        check({nm, " dac_len"}, te - pk_cyc, 24 * DAC_DIV);
    endtask

    initial begin : main
        int te, sv0, fs0, pk0, ld0, db0;
        logic [15:0] w, wb;
        logic [9:0] fd;

        tbl[0] = '{16'h02A5, 10'h3FC, 5, 10'h2A5, 11'h0FF};
        tbl[1] = '{16'hFFFF, 10'h000, 1, 10'h3FF, 11'h000};
        tbl[2] = '{16'h1234, 10'h2AB, 10, 10'h234, 11'h0AA};
        tbl[3] = '{16'h8001, 10'h155, 30, 10'h001, 11'h055};

        bus.sck = 1'b0;
        bus.sdo = 1'b0;
        bus.filt_done = 1'b0;
        bus.filt_data = '0;
        reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        tick();

        check("rst sample", 32'(bus.sample), 0);
        check("rst strobes", 32'({bus.sample_valid, bus.filt_start, bus.peak_en}), 0);
        check("rst dac", 32'({bus.dac_data, bus.dac_clk, bus.dac_load, bus.ldac}), 32'b0010);
        check("rst busy", 32'(bus.busy), 0);
        check("rst flags", 32'({bus.overrun, bus.filt_err, bus.frame_err}), 0);
        check("rst fcount", 32'(bus.frame_count), 0);

        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].fd, tbl[i].lat,
                    tbl[i].es, tbl[i].ed);
        end

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            fd = 10'($urandom);
            run_txn($sformatf("rnd%0d", i), w, fd, int'($urandom_range(1, 40)),
                    w[9:0], {2'b00, 1'b0, fd[9:2]});
        end
        check("flags clean", 32'({bus.overrun, bus.filt_err, bus.frame_err}), 0);

        pk0 = n_pk; ld0 = n_ld;
        send_frame(16'h0155, 16, 8);
        exp_fc = exp_fc + 16'd1;
        wait_idle("tmo", te);
        check("tmo len", te - fs_cyc, FILT_TO + 1);
        check("tmo filt_err", 32'(bus.filt_err), 1);
        check("tmo pk", n_pk - pk0, 0);
        check("tmo load", n_ld - ld0, 0);
        tick();
        bus.filt_done = 1'b1;
        repeat (3) tick();
        bus.filt_done = 1'b0;
        check("stray done busy", 32'(bus.busy), 0);

        sv0 = n_sv;
        send_frame(16'hFFFF, 7, 8);
        repeat (4096 + 20) tick();
        check("brk frame_err", 32'(bus.frame_err), 1);
        check("brk no sv", n_sv - sv0, 0);
        run_txn("brk next", 16'h0001, 10'h2F0, 8, 10'h001, 11'h0BC);

        sv0 = n_sv; fs0 = n_fs; pk0 = n_pk; db0 = n_dbit;
        send_frame(16'h00C3, 16, 8);
        exp_fc = exp_fc + 16'd1;
        fork
            send_frame(16'h7E5A, 16, 4);
            begin
                wait (cyc >= fs_cyc + 55);
                bus.filt_done = 1'b1;
                bus.filt_data = 10'h1E4;
                wait (cyc >= fs_cyc + 56);
                bus.filt_done = 1'b0;
            end
        join
        exp_fc = exp_fc + 16'd1;
        check("ovr overrun", 32'(bus.overrun), 1);
        check("ovr sample", 32'(bus.sample), 32'h25A);
        wait_idle("ovr", te);
        check("ovr sv", n_sv - sv0, 2);
        check("ovr fs", n_fs - fs0, 1);
        check("ovr pk", n_pk - pk0, 1);
        check("ovr dac_word", 32'(dac_cap), 32'h079);
        check("ovr dac_bits", n_dbit - db0, 11);
        check("ovr fcount", 32'(bus.frame_count), 32'(exp_fc));

        db0 = n_dbit;
        send_frame(16'h0200, 16, 8);
        bus.filt_done = 1'b1;
        bus.filt_data = 10'h3FF;
        tick();
        bus.filt_done = 1'b0;
        te = 0;
        while (n_dbit - db0 < 4 && te < 200) begin
            tick();
            te++;
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst dac_load", 32'(bus.dac_load), 1);
        check("mrst dac_clk", 32'(bus.dac_clk), 0);
        check("mrst busy", 32'(bus.busy), 0);
        check("mrst fcount", 32'(bus.frame_count), 0);
        check("mrst flags", 32'({bus.overrun, bus.filt_err, bus.frame_err}), 0);
        ld0 = n_ld;
        repeat (120) tick();
        check("mrst no load", n_ld - ld0, 0);
        check("mrst idle", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Single-clock controller that sequences the per-sample datapath of the heart-rate monitor.
- Oversamples the microcontroller SPI link (sck/sdo) in the clk domain and assembles 16-bit frames.
- For each frame, issues a sample strobe to the peak finder, then a start pulse to the FIR filter, then serializes the filtered result to the DAC.
- Replaces per-module sck bit counters with one central schedule, and flags overrun, filter-timeout and broken-frame conditions.

Parameters:
- FRAME_BITS, 16, SPI bits per frame.
- SAMPLE_W, 10, sample width, taken from the low bits of the frame.
- DAC_DIV, 4, clk cycles per DAC clock half-period (≥1).
- IDLE_TIMEOUT, 4096, clk cycles without an sck rising edge before a partial frame is discarded.
- FILT_TIMEOUT, 64, maximum clk cycles to wait for filt_done.
- DAC_ADDR, 2'b00, DAC channel address bits.
- DAC_RNG, 1'b0, DAC range bit.

Ports:
- clk  in  1  system clock, ≥8× sck frequency.
- reset  in  1  synchronous active-high reset.
- sck  in  1  SPI clock from MCU, asynchronous.
- sdo  in  1  SPI data from MCU, asynchronous.
- sample  out  SAMPLE_W  last complete sample.
- sample_valid  out  1  one-cycle strobe; sample is new.
- filt_start  out  1  one-cycle pulse; filter consumes sample.
- filt_done  in  1  filter result ready.
- filt_data  in  SAMPLE_W  filter result.
- peak_en  out  1  one-cycle pulse after filtered sample accepted.
- dac_data  out  1  DAC serial data.
- dac_clk  out  1  DAC serial clock.
- dac_load  out  1  DAC load, active low.
- ldac  out  1  tied 0.
- busy  out  1  FSM not IDLE.
- overrun  out  1  sticky: frame completed while busy.
- filt_err  out  1  sticky: filter timeout.
- frame_err  out  1  sticky: partial frame discarded.
- frame_count  out  16  completed frames, wraps.

Behaviour:
- Clock and reset:
  - One clock, clk; reset is synchronous and active-high.
  - Reset values: sample=0, all strobes=0, dac_data=0, dac_clk=0, dac_load=1, ldac=0, busy=0, all sticky flags=0, frame_count=0, bit_cnt=0, state=IDLE.
  - Reset asserted mid-operation aborts any transfer. dac_load returns high on the next edge and no partial DAC frame is completed.
- Input sync:
  - sck and sdo each pass through a 2-FF synchronizer.
  - sck rising edge is detected as sync 0→1. sdo is sampled in that same cycle.
- Frame assembly:
  - Shift register is MSB-first. bit_cnt increments on each sck rising edge.
  - On the FRAME_BITS-th edge, in the following cycle:
    - sample ← shreg[SAMPLE_W-1:0], including the final bit.
    - sample_valid=1 for one cycle.
    - frame_count+1, bit_cnt←0.
- Idle timeout:
  - If bit_cnt≠0 and IDLE_TIMEOUT consecutive cycles pass with no sck rising edge, bit_cnt←0 and frame_err←1.
  - No strobes are issued for the discarded partial frame.
- FSM states: IDLE, FILTER, DAC_SHIFT, DAC_LOAD.
- IDLE:
  - filt_start is asserted in the same cycle as sample_valid, and the FSM moves to FILTER.
- FILTER:
  - Waits for filt_done, with a cycle counter cleared on entry.
  - On filt_done: latch word = {DAC_ADDR, DAC_RNG, filt_data[SAMPLE_W-1:SAMPLE_W-8]}. Pulse peak_en in the next cycle and go to DAC_SHIFT.
  - If the counter reaches FILT_TIMEOUT before filt_done: filt_err←1, return to IDLE, no DAC update, no peak_en.
- DAC_SHIFT:
  - Shifts 11 bits, MSB first.
  - Each bit: dac_data is updated on entry, then dac_clk=0 for DAC_DIV cycles, then dac_clk=1 for DAC_DIV cycles.
  - After bit 11, dac_clk=0 and the FSM goes to DAC_LOAD.
- DAC_LOAD:
  - dac_load=0 for 2·DAC_DIV cycles, then 1. Return to IDLE.
- DAC timing:
  - Total DAC phase is 24·DAC_DIV cycles.
  - dac_data holds its last value outside DAC_SHIFT.
- Overrun:
  - A frame completing while state≠IDLE still updates sample and sample_valid.
  - filt_start is not issued and overrun←1. The in-flight sequence continues unaffected.
- busy=1 in every state except IDLE.
- filt_done received outside FILTER is ignored.

Test Plan:
- Frame assembly: reset, then a 16-bit SPI frame 0x02A5 at sck=clk/16 → sample=0x2A5 and sample_valid/filt_start pulse once, one cycle after the 16th edge; frame_count=1.
- Filter to DAC: filt_done with filt_data=0x3FC 5 cycles after filt_start (DAC_DIV=4) → peak_en one cycle later. dac_data serializes 0b000_11111111 over 11 dac_clk periods of 8 cycles each; then dac_load is low 8 cycles; busy falls after 96 cycles.
- Overrun: second frame completes during DAC_SHIFT → sample updated, no filt_start, overrun=1, first DAC word completes intact.
- Filter timeout: filt_done withheld → after 64 cycles filt_err=1, FSM in IDLE, dac_load stays 1, no peak_en.
- Broken frame: 7 sck edges then 4096 idle cycles → frame_err=1, bit_cnt=0; the next full frame 0x0001 gives sample=0x001.
- Reset mid-operation: assert reset during DAC_SHIFT bit 5 → next cycle dac_load=1, dac_clk=0, busy=0, frame_count=0, all flags cleared.
